sdram_arbit: RTL and testbench

SDRAM command arbiter between the SDRAM controller's sub-modules (init, auto-refresh, write, read) and the SDRAM command/address pins. It holds the bus for the init sequence until `init_end`, then grants the bus to one requester at a time through a req/ack/end handshake. Grants are prioritised as refresh first, then write and read with alternation between them. It drives the selected requester's command, address and bank onto the SDRAM pins, and drives NOP when idle.

---
 rtl/sdram_arbit.sv | 166 ++++++++++++++++
 tb/tb_sdram_arbit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: the init sequence owns the pins until init_end, then
// refresh, write and read are granted one at a time via req/ack/end handshakes.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int         ADDR_W  = 13
) (
    input  logic              sysclk_100M,
    input  logic              rst,

    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [1:0]        init_bank,
    input  logic              init_end,

    input  logic              arbit_ref_req,
    output logic              arbit_ref_ack,
    input  logic              arbit_ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [1:0]        ref_bank,

    input  logic              arbit_write_req,
    output logic              arbit_write_ack,
    input  logic              arbit_write_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,

    input  logic              arbit_read_req,
    output logic              arbit_read_ack,
    input  logic              arbit_read_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,

    output logic [3:0]        cmd_reg,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [1:0]        sdram_bank_addr,
    output logic              sdram_cke
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_wr;
    logic   r_ref_ack;
    logic   r_write_ack;
    logic   r_read_ack;
    logic   r_cke;

    always_ff @(posedge sysclk_100M) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first, so no branch leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (init_end) begin
                    w_state_nxt = ST_ARBIT;
                end
            end
            ST_ARBIT: begin
                // Refresh wins outright; write/read alternate when both are waiting.
                if (arbit_ref_req) begin
                    w_state_nxt = ST_AREF;
                end else if (arbit_write_req && arbit_read_req) begin
                    w_state_nxt = r_last_wr ? ST_READ : ST_WRITE;
                end else if (arbit_write_req) begin
                    w_state_nxt = ST_WRITE;
                end else if (arbit_read_req) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_AREF: begin
                if (arbit_ref_end) begin
                    w_state_nxt = ST_ARBIT;
                end
            end
            ST_WRITE: begin
                if (arbit_write_end) begin
                    w_state_nxt = ST_ARBIT;
                end
            end
            ST_READ: begin
                if (arbit_read_end) begin
                    w_state_nxt = ST_ARBIT;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            r_ref_ack   <= 1'b0;
            r_write_ack <= 1'b0;
            r_read_ack  <= 1'b0;
            r_last_wr   <= 1'b0;
            r_cke       <= 1'b0;
        end else begin
            r_ref_ack   <= (w_state_nxt == ST_AREF);
            r_write_ack <= (w_state_nxt == ST_WRITE);
            r_read_ack  <= (w_state_nxt == ST_READ);
            r_cke       <= 1'b1;
            if (r_state == ST_ARBIT && w_state_nxt == ST_WRITE) begin
                r_last_wr <= 1'b1;
            end else if (r_state == ST_ARBIT && w_state_nxt == ST_READ) begin
                r_last_wr <= 1'b0;
            end
        end
    end

    assign arbit_ref_ack   = r_ref_ack;
    assign arbit_write_ack = r_write_ack;
    assign arbit_read_ack  = r_read_ack;
    assign sdram_cke       = r_cke;

    // Output mux follows the state register, so a grant's first cycle already drives its command.
    always_comb begin
        cmd_reg         = CMD_NOP;
        sdram_addr      = '0;
        sdram_bank_addr = 2'b00;
        case (r_state)
            ST_INIT: begin
                cmd_reg         = init_cmd;
                sdram_addr      = init_addr;
                sdram_bank_addr = init_bank;
            end
            ST_AREF: begin
                cmd_reg         = ref_cmd;
                sdram_addr      = ref_addr;
                sdram_bank_addr = ref_bank;
            end
            ST_WRITE: begin
                cmd_reg         = wr_cmd;
                sdram_addr      = wr_addr;
                sdram_bank_addr = wr_bank;
            end
            ST_READ: begin
                cmd_reg         = rd_cmd;
                sdram_addr      = rd_addr;
                sdram_bank_addr = rd_bank;
            end
            default: begin
                cmd_reg         = CMD_NOP;
                sdram_addr      = '0;
                sdram_bank_addr = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed handshakes plus a grant-order scoreboard.
module tb_sdram_arbit;

    localparam logic [3:0] NOP = 4'b0111;
    localparam int         AW  = 13;

    logic          clk;
    logic          rst;
    logic [3:0]    init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic [AW-1:0] init_addr, ref_addr, wr_addr, rd_addr;
    logic [1:0]    init_bank, ref_bank, wr_bank, rd_bank;
    logic          init_end;
    logic          ref_req, ref_end, wr_req, wr_end, rd_req, rd_end;
    logic          ref_ack, wr_ack, rd_ack;
    logic [3:0]    cmd_reg;
    logic [AW-1:0] sdram_addr;
    logic [1:0]    sdram_bank;
    logic          cke;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [1:0]    kind;   // 0 refresh, 1 write, 2 read
        logic [3:0]    cmd;
        logic [AW-1:0] addr;
        logic [1:0]    bank;
    } grant_t;

    grant_t exp_q[$];

    sdram_arbit #(.CMD_NOP(NOP), .ADDR_W(AW)) dut (
        .sysclk_100M     (clk),
        .rst             (rst),
        .init_cmd        (init_cmd),
        .init_addr       (init_addr),
        .init_bank       (init_bank),
        .init_end        (init_end),
        .arbit_ref_req   (ref_req),
        .arbit_ref_ack   (ref_ack),
        .arbit_ref_end   (ref_end),
        .ref_cmd         (ref_cmd),
        .ref_addr        (ref_addr),
        .ref_bank        (ref_bank),
        .arbit_write_req (wr_req),
        .arbit_write_ack (wr_ack),
        .arbit_write_end (wr_end),
        .wr_cmd          (wr_cmd),
        .wr_addr         (wr_addr),
        .wr_bank         (wr_bank),
        .arbit_read_req  (rd_req),
        .arbit_read_ack  (rd_ack),
        .arbit_read_end  (rd_end),
        .rd_cmd          (rd_cmd),
        .rd_addr         (rd_addr),
        .rd_bank         (rd_bank),
        .cmd_reg         (cmd_reg),
        .sdram_addr      (sdram_addr),
        .sdram_bank_addr (sdram_bank),
        .sdram_cke       (cke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic grant_t mk_grant(input logic [1:0] k);
        case (k)
            2'd0:    return {k, ref_cmd, ref_addr, ref_bank};
            2'd1:    return {k, wr_cmd, wr_addr, wr_bank};
            default: return {k, rd_cmd, rd_addr, rd_bank};
        endcase
    endfunction

    task automatic set_req(input int i, input logic v);
        case (i)
            0:       ref_req = v;
            1:       wr_req  = v;
            default: rd_req  = v;
        endcase
    endtask

    task automatic set_end(input int i, input logic v);
        case (i)
            0:       ref_end = v;
            1:       wr_end  = v;
            default: rd_end  = v;
        endcase
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) tick;
        n_total++;
        if ({cke, ref_ack, wr_ack, rd_ack} !== 4'b0000) begin
            $display("FAIL reset_state: cke/acks=%b want 0000", {cke, ref_ack, wr_ack, rd_ack});
        end else n_pass++;

        rst = 1'b0;
        tick;
        n_total++;
        if (cke !== 1'b1) $display("FAIL cke_release: cke=%b want 1", cke);
        else n_pass++;
        n_total++;
        if ({cmd_reg, sdram_addr, sdram_bank} !== {init_cmd, init_addr, init_bank}) begin
            $display("FAIL init_mux: cmd=%b addr=%h bank=%b want %b %h %b",
                     cmd_reg, sdram_addr, sdram_bank, init_cmd, init_addr, init_bank);
        end else n_pass++;

        rd_req = 1'b1;
        repeat (3) tick;
        n_total++;
        if (rd_ack !== 1'b0) $display("FAIL init_no_ack: read_ack=%b want 0", rd_ack);
        else n_pass++;

        init_end = 1'b1;
        tick;
        init_end = 1'b0;
        n_total++;
        if ({cmd_reg, sdram_addr, sdram_bank, rd_ack} !== {NOP, {AW{1'b0}}, 2'b00, 1'b0}) begin
            $display("FAIL init_to_arbit: cmd=%b addr=%h bank=%b ack=%b want %b 0 0 0",
                     cmd_reg, sdram_addr, sdram_bank, rd_ack, NOP);
        end else n_pass++;

        tick;
        n_total++;
        if (rd_ack !== 1'b1 || cmd_reg !== rd_cmd) begin
            $display("FAIL first_read_grant: ack=%b cmd=%b want 1 %b", rd_ack, cmd_reg, rd_cmd);
        end else n_pass++;
        rd_req = 1'b0;
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        n_total++;
        if (rd_ack !== 1'b0 || cmd_reg !== NOP) begin
            $display("FAIL first_read_release: ack=%b cmd=%b want 0 %b", rd_ack, cmd_reg, NOP);
        end else n_pass++;
    endtask

    task automatic test_single_read;
        rd_req = 1'b1;
        tick;
        n_total++;
        if (rd_ack !== 1'b1) $display("FAIL read_grant: ack=%b want 1", rd_ack);
        else n_pass++;
        n_total++;
        if ({cmd_reg, sdram_addr, sdram_bank} !== {rd_cmd, 13'h0A5, 2'b01}) begin
            $display("FAIL read_mirror: cmd=%b addr=%h bank=%b want %b 0a5 01",
                     cmd_reg, sdram_addr, sdram_bank, rd_cmd);
        end else n_pass++;
        rd_req = 1'b0;
        wr_end = 1'b1;   // stray end from a requester that holds no grant
        tick;
        wr_end = 1'b0;
        tick;
        n_total++;
        if (rd_ack !== 1'b1 || cmd_reg !== rd_cmd) begin
            $display("FAIL stray_end: ack=%b cmd=%b want 1 %b", rd_ack, cmd_reg, rd_cmd);
        end else n_pass++;
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        n_total++;
        if (rd_ack !== 1'b0 || cmd_reg !== NOP) begin
            $display("FAIL read_release: ack=%b cmd=%b want 0 %b", rd_ack, cmd_reg, NOP);
        end else n_pass++;
        init_end = 1'b1; // stray init_end outside INIT
        tick;
        init_end = 1'b0;
        tick;
        n_total++;
        if ({ref_ack, wr_ack, rd_ack} !== 3'b000 || cmd_reg !== NOP) begin
            $display("FAIL stray_init_end: acks=%b cmd=%b want 000 %b",
                     {ref_ack, wr_ack, rd_ack}, cmd_reg, NOP);
        end else n_pass++;
    endtask

    // Behaves as the three requesters: hold req until ack, burst 3 cycles, pulse end.
    // Each new grant is popped from exp_q and must follow an idle NOP cycle.
    task automatic run_sched(input int n_ref, input int n_wr, input int n_rd, input int budget);
        int         left[3];
        int         hold[3];
        logic [2:0] busy;
        logic [2:0] ack;
        logic [2:0] prev_ack;
        logic [3:0] prev_cmd;
        int         cyc;
        grant_t     g;
        grant_t     obs;
        left     = '{n_ref, n_wr, n_rd};
        hold     = '{0, 0, 0};
        busy     = 3'b000;
        prev_ack = {rd_ack, wr_ack, ref_ack};
        prev_cmd = cmd_reg;
        for (int i = 0; i < 3; i++) set_req(i, left[i] > 0);
        cyc = 0;
        while ((exp_q.size() > 0 || busy != 3'b000) && cyc < budget) begin
            tick;
            cyc++;
            for (int i = 0; i < 3; i++) set_end(i, 1'b0);
            ack = {rd_ack, wr_ack, ref_ack};
            for (int i = 0; i < 3; i++) begin
                if (ack[i] && !prev_ack[i]) begin
                    obs = {2'(i), cmd_reg, sdram_addr, sdram_bank};
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL grant_order: unexpected grant kind=%0d, want none", i);
                    end else begin
                        g = exp_q.pop_front();
                        if (obs !== g || $countones(ack) != 1) begin
                            $display("FAIL grant_order: got kind=%0d cmd=%b addr=%h bank=%b acks=%b, want kind=%0d cmd=%b addr=%h bank=%b",
                                     obs.kind, obs.cmd, obs.addr, obs.bank, ack, g.kind, g.cmd, g.addr, g.bank);
                        end else n_pass++;
                    end
                    n_total++;
                    if (prev_ack !== 3'b000 || prev_cmd !== NOP) begin
                        $display("FAIL nop_gap: previous acks=%b cmd=%b want 000 %b", prev_ack, prev_cmd, NOP);
                    end else n_pass++;
                    busy[i] = 1'b1;
                    hold[i] = 2;
                    left[i]--;
                    set_req(i, 1'b0);
                end else if (busy[i] && ack[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    if (hold[i] == 0) begin
                        set_end(i, 1'b1);
                        hold[i] = -1;
                    end
                end else if (busy[i] && !ack[i]) begin
                    busy[i] = 1'b0;
                    if (left[i] > 0) set_req(i, 1'b1);
                end
            end
            prev_ack = ack;
            prev_cmd = cmd_reg;
        end
        n_total++;
        if (exp_q.size() != 0 || busy != 3'b000) begin
            $display("FAIL sched_done: %0d grants outstanding, busy=%b after %0d cycles",
                     exp_q.size(), busy, cyc);
        end else n_pass++;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b0);
            set_end(i, 1'b0);
        end
        tick;
    endtask

    task automatic test_priority;
        exp_q.push_back(mk_grant(2'd0));
        exp_q.push_back(mk_grant(2'd1));
        exp_q.push_back(mk_grant(2'd2));
        run_sched(1, 1, 1, 60);
    endtask

    task automatic test_alternation;
        exp_q.push_back(mk_grant(2'd1));
        exp_q.push_back(mk_grant(2'd2));
        exp_q.push_back(mk_grant(2'd1));
        exp_q.push_back(mk_grant(2'd2));
        run_sched(0, 2, 2, 80);
    endtask

    task automatic test_ref_during_write;
        wr_req = 1'b1;
        tick;
        n_total++;
        if (wr_ack !== 1'b1) $display("FAIL rdw_write_grant: ack=%b want 1", wr_ack);
        else n_pass++;
        wr_req = 1'b0;
        tick;
        ref_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_total++;
            if ({wr_ack, ref_ack} !== 2'b10 || cmd_reg !== wr_cmd) begin
                $display("FAIL rdw_no_preempt: wr/ref ack=%b cmd=%b want 10 %b", {wr_ack, ref_ack}, cmd_reg, wr_cmd);
            end else n_pass++;
        end
        wr_end = 1'b1;
        tick;
        wr_end = 1'b0;
        n_total++;
        if ({wr_ack, ref_ack} !== 2'b00 || cmd_reg !== NOP) begin
            $display("FAIL rdw_release: wr/ref ack=%b cmd=%b want 00 %b", {wr_ack, ref_ack}, cmd_reg, NOP);
        end else n_pass++;
        tick;
        n_total++;
        if (ref_ack !== 1'b1 || cmd_reg !== ref_cmd) begin
            $display("FAIL rdw_ref_grant: ack=%b cmd=%b want 1 %b", ref_ack, cmd_reg, ref_cmd);
        end else n_pass++;
        ref_req = 1'b0;
        ref_end = 1'b1;
        tick;
        ref_end = 1'b0;
        n_total++;
        if (ref_ack !== 1'b0) $display("FAIL rdw_ref_release: ack=%b want 0", ref_ack);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        tick;
        n_total++;
        if (rd_ack !== 1'b1) $display("FAIL rmr_grant: ack=%b want 1", rd_ack);
        else n_pass++;
        rst = 1'b1;
        tick;
        n_total++;
        if ({rd_ack, cke} !== 2'b00 || {cmd_reg, sdram_addr, sdram_bank} !== {init_cmd, init_addr, init_bank}) begin
            $display("FAIL rmr_reset: ack=%b cke=%b cmd=%b addr=%h bank=%b want 0 0 %b %h %b",
                     rd_ack, cke, cmd_reg, sdram_addr, sdram_bank, init_cmd, init_addr, init_bank);
        end else n_pass++;
        rst = 1'b0;
        tick;
        rd_end = 1'b1;
        tick;
        rd_end = 1'b0;
        tick;
        n_total++;
        if (rd_ack !== 1'b0 || cke !== 1'b1 || cmd_reg !== init_cmd) begin
            $display("FAIL rmr_stray_end: ack=%b cke=%b cmd=%b want 0 1 %b", rd_ack, cke, cmd_reg, init_cmd);
        end else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        init_end  = 1'b0;
        ref_req   = 1'b0;
        ref_end   = 1'b0;
        wr_req    = 1'b0;
        wr_end    = 1'b0;
        rd_req    = 1'b0;
        rd_end    = 1'b0;
        init_cmd  = 4'b0010;
        init_addr = 13'h0123;
        init_bank = 2'b11;
        ref_cmd   = 4'b0001;
        ref_addr  = 13'h0400;
        ref_bank  = 2'b00;
        wr_cmd    = 4'b0100;
        wr_addr   = 13'h1F0;
        wr_bank   = 2'b10;
        rd_cmd    = 4'b0101;
        rd_addr   = 13'h0A5;
        rd_bank   = 2'b01;

        test_reset();
        test_single_read();
        test_priority();
        test_alternation();
        test_ref_during_write();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
